retire_tracker: RTL

RETIRE_TRACKER -- requirements
Module: retire_tracker

---
 rtl/retire_tracker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/retire_tracker.sv
// retire_tracker
//   Collects up to NRET retirements per cycle from writeback, drops stall
//   replays (same order number as the previous accepted retirement), checks
//   that accepted order numbers are consecutive, and queues the accepted
//   records in a DEPTH-entry FIFO for a ready/valid consumer.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   i_valid[NRET]         per-channel retire valid
//   i_order[NRET][64]     per-channel instruction order number
//   i_inst[NRET][32]      per-channel instruction word
//   i_pc_rdata[NRET][32]  per-channel PC
//   i_pc_wdata[NRET][32]  per-channel next PC
//   o_valid / i_ready     head-of-FIFO handshake
//   o_order, o_inst, o_pc_rdata, o_pc_wdata   head record (don't-care when !o_valid)
//   o_order_err           sticky: an accepted order was not last+1
//   o_overflow            sticky: an accepted record did not fit in the FIFO
//   o_retire_count        accepted retirements (wraps at 64 bits)
//   o_dup_count           discarded duplicates (saturates)
module retire_tracker #(
    parameter int NRET  = 1,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRET-1:0]       i_valid,
    input  logic [NRET-1:0][63:0] i_order,
    input  logic [NRET-1:0][31:0] i_inst,
    input  logic [NRET-1:0][31:0] i_pc_rdata,
    input  logic [NRET-1:0][31:0] i_pc_wdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [63:0]           o_order,
    output logic [31:0]           o_inst,
    output logic [31:0]           o_pc_rdata,
    output logic [31:0]           o_pc_wdata,
    output logic                  o_order_err,
    output logic                  o_overflow,
    output logic [63:0]           o_retire_count,
    output logic [31:0]           o_dup_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;   // occupancy needs to reach DEPTH itself

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rec_t;

    rec_t mem [DEPTH];

    logic [63:0]   last_order;
    logic [63:0]   exp_order;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;

    // per-cycle results of walking the channels in index order
    logic [63:0]           lo_nxt;
    logic [63:0]           eo_nxt;
    logic                  seq_err;
    logic                  drop;
    logic [CW-1:0]         n_acc;
    logic [CW-1:0]         n_dup;
    logic [CW-1:0]         n_push;
    logic [CW-1:0]         free;
    logic                  pop;
    logic [NRET-1:0]       wen;
    logic [NRET-1:0][AW-1:0] waddr;
    logic [32:0]           dup_sum;

    assign o_valid    = (count != '0);
    assign pop        = o_valid && i_ready;
    assign o_order    = mem[rptr].order;
    assign o_inst     = mem[rptr].inst;
    assign o_pc_rdata = mem[rptr].pc_rdata;
    assign o_pc_wdata = mem[rptr].pc_wdata;

    always_comb begin
        lo_nxt  = last_order;
        eo_nxt  = exp_order;
        seq_err = 1'b0;
        drop    = 1'b0;
        n_acc   = '0;
        n_dup   = '0;
        n_push  = '0;
        wen     = '0;
        waddr   = '0;
        // a same-cycle pop frees its slot for this cycle's pushes
        free    = CW'(DEPTH) - count + CW'(pop);
        for (int c = 0; c < NRET; c++) begin
            if (i_valid[c]) begin
                if (i_order[c] != lo_nxt) begin
                    lo_nxt = i_order[c];
                    if (i_order[c] != eo_nxt) seq_err = 1'b1;
                    eo_nxt = i_order[c] + 64'd1;
                    n_acc  = n_acc + CW'(1);
                    // lower-index channels claim slots first; the rest drop
                    if (n_push < free) begin
                        wen[c]   = 1'b1;
                        waddr[c] = wptr + AW'(n_push);
                        n_push   = n_push + CW'(1);
                    end else begin
                        drop = 1'b1;
                    end
                end else begin
                    n_dup = n_dup + CW'(1);
                end
            end
        end
        dup_sum = {1'b0, o_dup_count} + 33'(n_dup);
    end

    // storage has no reset: contents are only observed behind count
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NRET; c++) begin
                if (wen[c]) begin
                    mem[waddr[c]] <= '{order:    i_order[c],
                                       inst:     i_inst[c],
                                       pc_rdata: i_pc_rdata[c],
                                       pc_wdata: i_pc_wdata[c]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_order     <= '1;
            exp_order      <= '0;
            rptr           <= '0;
            wptr           <= '0;
            count          <= '0;
            o_order_err    <= 1'b0;
            o_overflow     <= 1'b0;
            o_retire_count <= '0;
            o_dup_count    <= '0;
        end else begin
            last_order     <= lo_nxt;
            exp_order      <= eo_nxt;
            wptr           <= wptr + AW'(n_push);
            if (pop) rptr  <= rptr + AW'(1);
            count          <= count + n_push - CW'(pop);
            o_order_err    <= o_order_err | seq_err;
            o_overflow     <= o_overflow | drop;
            o_retire_count <= o_retire_count + 64'(n_acc);
            o_dup_count    <= dup_sum[32] ? '1 : dup_sum[31:0];
        end
    end

endmodule
